rename_dispatch_buf: RTL
========================

// Module: rename_dispatch_buf
// PURPOSE
//  Parametrised rename/dispatch stage: reads RAT operands for each decoded instruction and
//  queues it in a DEPTH-entry in-order dispatch buffer. Routes the buffer head to one of
//  NUM_UNITS reservation-station channels (exers/lsq/csr/...), each with its own stall.
//  While waiting, buffered operands snoop the CDB and capture results. Sits between decode, RAT and RS.
// PARAMETERS
//  DEPTH      4  dispatch buffer entries, >=2, power of two
//  NUM_UNITS  3  destination channels; index 0=EXE, 1=LSQ, 2=CSR
//  ROBW       7  ROB id / operand tag width, <=32
// PORTS
//  clk                 in   1          clock, all state on posedge
//  rst                 in   1          asynchronous, active-low reset
//  decode_rename_valid in   1          decode presents an instruction
//  decode_addr         in   30         PC[31:2]
//  decode_rsop         in   5          RS opcode
//  decode_robid        in   ROBW       ROB id of instruction
//  decode_rd           in   6          destination register
//  decode_uses_rs1/rs2/imm/pc  in 1 ea operand-source selects
//  decode_unit         in   clog2(NUM_UNITS) destination channel index
//  decode_rs1/rs2      in   5 ea       source register numbers
//  decode_imm          in   32         immediate
//  rename_stall        out  1          decode must hold; instruction not accepted
//  rename_rat_valid/rd/robid/rs1/rs2  out  1/6/ROBW/5/5  RAT lookup+allocate (comb from decode_*)
//  rat_rs1_valid/rat_rs1_tagval  in  1/32  rs1 ready flag; value if ready, else tag in [ROBW-1:0]
//  rat_rs2_valid/rat_rs2_tagval  in  1/32  same for rs2
//  cdb_valid/cdb_tag/cdb_value   in  1/ROBW/32  result broadcast
//  rename_write        out  NUM_UNITS  one-hot write strobe to selected RS channel
//  rename_op/robid/rd/imm  out  5/ROBW/6/32  head instruction fields
//  rename_op1ready/op1/op2ready/op2  out  1/32/1/32  head operands (tag when not ready)
//  unit_stall          in   NUM_UNITS  per-channel RS full
//  rob_flush           in   1          squash all buffered work
// BEHAVIOUR
//  Reset (rst=0, async): count=0, pointers=0, all entry valids=0; rename_stall=0,
//   rename_write=0, all data outputs 0.
//  RAT outputs are pure pass-through of decode_* (rat_valid = decode_rename_valid & ~rename_stall).
//  rename_stall = (count==DEPTH); registered-state only, no comb path from unit_stall.
//  Enqueue: decode_rename_valid & ~rename_stall & ~rob_flush -> write tail, tail++, latency 1 to head.
//  Operand build at enqueue:
//   {rs1,pc}=00: op1=imm rdy, op2=0 rdy | 01: op1={addr,2'b00} rdy, op2=imm rdy
//   rs1=1 (pc ignored): op1=RAT rs1; op2 = rs2 ? RAT rs2 : imm ? imm : 0 (rdy).
//   No X outputs for any select combination.
//  Snoop: any valid entry operand with ready=0 and tag==cdb_tag while cdb_valid -> value=cdb_value, ready=1
//   next cycle. Also applied to RAT results at enqueue cycle (same-cycle CDB hit captured ready).
//  Head bypass: outputs show CDB-matched value/ready in the same cycle the broadcast occurs.
//  Dispatch: head valid & ~unit_stall[head.unit] -> rename_write[head.unit]=1 that cycle, head++.
//   rename_write is 0 whenever empty or stalled; data outputs hold head fields regardless.
//  Simultaneous enqueue+dispatch: count unchanged. Pointers wrap modulo DEPTH.
//  Full: no enqueue; dispatch that cycle frees a slot; rename_stall drops next cycle.
//  rob_flush: rename_write forced 0 that cycle; next cycle count=0, pointers reset, entries
//   invalid; same-cycle decode input dropped. Flush+full -> stall deasserts next cycle.
//  Reset mid-operation: immediate clear, all in-flight entries lost.
//  decode_unit >= NUM_UNITS: entry treated as unit 0.
// STRUCTURE
//  Shared pkg rename_pkg: unit index localparams (UNIT_EXE/LSQ/CSR), dispatch entry struct
//   {op,robid,rd,unit,imm,op1,op1rdy,op2,op2rdy}, operand-select encoding.
//  Sub-module rename_opnd_snoop: one operand slot (value/ready/tag compare + capture), instanced
//   2 x DEPTH plus 2 at enqueue path. FIFO control inline.
// TESTING
//  1 LUI: uses_rs1=0,pc=0,imm=0x12345000,unit=0 -> next cycle rename_write=001, op1=0x12345000 rdy, op2=0 rdy.
//  2 AUIPC: addr=0x400>>2,imm=0x10 -> op1=0x400, op2=0x10, both rdy.
//  3 Snoop: rs1 not ready tag=5, hold unit_stall[0]=1; cdb tag 5 value 0xDEAD -> op1=0xDEAD rdy, same cycle; dispatch on release.
//  4 Full: unit_stall=all 1, push 4 -> rename_stall=1, 5th held; release -> one write/cycle, in order, stall drops after first.
//  5 Routing: units 2,1,0 with unit_stall[1]=1 -> csr write, then head blocks (no bypass), exe waits behind lsq.
//  6 Flush with 3 buffered + decode valid -> no writes, count=0 next cycle, then new enqueue dispatches normally.

Source files
------------

// File: rtl/rename_pkg.sv
// Shared rename/dispatch types: channel indices, dispatch-buffer entry layout, operand-select codes.
// Field widths are sized to their maxima so the entry layout stays fixed across parameterisations.
package rename_pkg;

   localparam int UNIT_EXE  = 0;
   localparam int UNIT_LSQ  = 1;
   localparam int UNIT_CSR  = 2;

   localparam int ROBW_MAX  = 32;
   localparam int UNITW_MAX = 4;

   // {uses_rs1, uses_pc}; any code with uses_rs1 set reads the RAT and ignores uses_pc.
   localparam logic [1:0] OPSEL_IMM = 2'b00;
   localparam logic [1:0] OPSEL_PC  = 2'b01;

   typedef struct packed {
      logic [4:0]           op;
      logic [ROBW_MAX-1:0]  robid;
      logic [5:0]           rd;
      logic [UNITW_MAX-1:0] unit;
      logic [31:0]          imm;
      logic [31:0]          op1;
      logic                 op1rdy;
      logic [31:0]          op2;
      logic                 op2rdy;
   } disp_entry_t;

endpackage

// File: rtl/rename_opnd_snoop.sv
// One operand slot: a not-ready operand whose tag matches a live CDB broadcast takes the result.
// Purely combinational; the owning flop captures the result on the next edge.
module rename_opnd_snoop #(
   parameter int ROBW = 7
) (
   input  logic            snoop_en,
   input  logic [31:0]     val_in,
   input  logic            rdy_in,
   input  logic            cdb_valid,
   input  logic [ROBW-1:0] cdb_tag,
   input  logic [31:0]     cdb_value,
   output logic [31:0]     val_out,
   output logic            rdy_out
);

   logic hit;

   assign hit     = snoop_en & cdb_valid & ~rdy_in & (val_in[ROBW-1:0] == cdb_tag);
   assign val_out = hit ? cdb_value : val_in;
   assign rdy_out = rdy_in | hit;

endmodule

// File: rtl/rename_dispatch_buf.sv
// Rename/dispatch: RAT operand build into a DEPTH-entry in-order buffer, head routed to one RS channel.
// Enqueue-to-head latency 1; rename_stall only when full (registered), head blocks on its channel's unit_stall.
module rename_dispatch_buf
   import rename_pkg::*;
#(
   parameter int DEPTH     = 4,
   parameter int NUM_UNITS = 3,
   parameter int ROBW      = 7,
   parameter int UW        = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 decode_rename_valid,
   input  logic [29:0]          decode_addr,
   input  logic [4:0]           decode_rsop,
   input  logic [ROBW-1:0]      decode_robid,
   input  logic [5:0]           decode_rd,
   input  logic                 decode_uses_rs1,
   input  logic                 decode_uses_rs2,
   input  logic                 decode_uses_imm,
   input  logic                 decode_uses_pc,
   input  logic [UW-1:0]        decode_unit,
   input  logic [4:0]           decode_rs1,
   input  logic [4:0]           decode_rs2,
   input  logic [31:0]          decode_imm,
   output logic                 rename_stall,
   output logic                 rename_rat_valid,
   output logic [5:0]           rename_rat_rd,
   output logic [ROBW-1:0]      rename_rat_robid,
   output logic [4:0]           rename_rat_rs1,
   output logic [4:0]           rename_rat_rs2,
   input  logic                 rat_rs1_valid,
   input  logic [31:0]          rat_rs1_tagval,
   input  logic                 rat_rs2_valid,
   input  logic [31:0]          rat_rs2_tagval,
   input  logic                 cdb_valid,
   input  logic [ROBW-1:0]      cdb_tag,
   input  logic [31:0]          cdb_value,
   output logic [NUM_UNITS-1:0] rename_write,
   output logic [4:0]           rename_op,
   output logic [ROBW-1:0]      rename_robid,
   output logic [5:0]           rename_rd,
   output logic [31:0]          rename_imm,
   output logic                 rename_op1ready,
   output logic [31:0]          rename_op1,
   output logic                 rename_op2ready,
   output logic [31:0]          rename_op2,
   input  logic [NUM_UNITS-1:0] unit_stall,
   input  logic                 rob_flush
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   disp_entry_t      ent_q [DEPTH];
   disp_entry_t      ent_d [DEPTH];
   logic [DEPTH-1:0] vld_q, vld_d;
   logic [PW-1:0]    head_q, head_d;
   logic [PW-1:0]    tail_q, tail_d;
   logic [CW-1:0]    count_q, count_d;

   logic [31:0]      snp_op1 [DEPTH];
   logic [31:0]      snp_op2 [DEPTH];
   logic [DEPTH-1:0] snp_op1rdy, snp_op2rdy;

   logic             enq, disp;
   logic [UW-1:0]    dec_unit, head_unit;
   disp_entry_t      new_ent, head_ent;
   logic [31:0]      raw_op1, raw_op2, enq_op1, enq_op2;
   logic             raw_op1rdy, raw_op2rdy, enq_op1rdy, enq_op2rdy;

   assign rename_stall     = (count_q == CW'(DEPTH));
   assign rename_rat_valid = decode_rename_valid & ~rename_stall;
   assign rename_rat_rd    = decode_rd;
   assign rename_rat_robid = decode_robid;
   assign rename_rat_rs1   = decode_rs1;
   assign rename_rat_rs2   = decode_rs2;

   assign enq      = decode_rename_valid & ~rename_stall & ~rob_flush;
   assign dec_unit = (32'(decode_unit) < 32'(NUM_UNITS)) ? decode_unit : UW'(UNIT_EXE);

   always_comb begin
      raw_op1    = decode_imm;
      raw_op1rdy = 1'b1;
      raw_op2    = '0;
      raw_op2rdy = 1'b1;
      case ({decode_uses_rs1, decode_uses_pc})
         OPSEL_IMM: raw_op1 = decode_imm;
         OPSEL_PC: begin
            raw_op1 = {decode_addr, 2'b00};
            raw_op2 = decode_imm;
         end
         default: begin
            raw_op1    = rat_rs1_tagval;
            raw_op1rdy = rat_rs1_valid;
            if (decode_uses_rs2) begin
               raw_op2    = rat_rs2_tagval;
               raw_op2rdy = rat_rs2_valid;
            end else if (decode_uses_imm) begin
               raw_op2 = decode_imm;
            end
         end
      endcase
   end

   // RAT results can be satisfied by the very broadcast seen during the enqueue cycle.
   rename_opnd_snoop #(.ROBW(ROBW)) u_enq_op1 (
      .snoop_en (1'b1),       .val_in  (raw_op1),    .rdy_in    (raw_op1rdy),
      .cdb_valid(cdb_valid),  .cdb_tag (cdb_tag),    .cdb_value (cdb_value),
      .val_out  (enq_op1),    .rdy_out (enq_op1rdy)
   );
   rename_opnd_snoop #(.ROBW(ROBW)) u_enq_op2 (
      .snoop_en (1'b1),       .val_in  (raw_op2),    .rdy_in    (raw_op2rdy),
      .cdb_valid(cdb_valid),  .cdb_tag (cdb_tag),    .cdb_value (cdb_value),
      .val_out  (enq_op2),    .rdy_out (enq_op2rdy)
   );

   always_comb begin
      new_ent        = '0;
      new_ent.op     = decode_rsop;
      new_ent.robid  = ROBW_MAX'(decode_robid);
      new_ent.rd     = decode_rd;
      new_ent.unit   = UNITW_MAX'(dec_unit);
      new_ent.imm    = decode_imm;
      new_ent.op1    = enq_op1;
      new_ent.op1rdy = enq_op1rdy;
      new_ent.op2    = enq_op2;
      new_ent.op2rdy = enq_op2rdy;
   end

   for (genvar i = 0; i < DEPTH; i++) begin : g_ent
      rename_opnd_snoop #(.ROBW(ROBW)) u_op1 (
         .snoop_en (vld_q[i]),      .val_in  (ent_q[i].op1),  .rdy_in    (ent_q[i].op1rdy),
         .cdb_valid(cdb_valid),     .cdb_tag (cdb_tag),       .cdb_value (cdb_value),
         .val_out  (snp_op1[i]),    .rdy_out (snp_op1rdy[i])
      );
      rename_opnd_snoop #(.ROBW(ROBW)) u_op2 (
         .snoop_en (vld_q[i]),      .val_in  (ent_q[i].op2),  .rdy_in    (ent_q[i].op2rdy),
         .cdb_valid(cdb_valid),     .cdb_tag (cdb_tag),       .cdb_value (cdb_value),
         .val_out  (snp_op2[i]),    .rdy_out (snp_op2rdy[i])
      );
   end

   assign head_ent     = ent_q[head_q];
   assign head_unit    = head_ent.unit[UW-1:0];
   assign disp         = vld_q[head_q] & ~unit_stall[head_unit] & ~rob_flush;
   assign rename_write = disp ? (NUM_UNITS'(1) << head_unit) : '0;

   // Head operands come through the snoop path so a broadcast is visible the cycle it happens.
   assign rename_op       = head_ent.op;
   assign rename_robid    = head_ent.robid[ROBW-1:0];
   assign rename_rd       = head_ent.rd;
   assign rename_imm      = head_ent.imm;
   assign rename_op1      = snp_op1[head_q];
   assign rename_op1ready = snp_op1rdy[head_q];
   assign rename_op2      = snp_op2[head_q];
   assign rename_op2ready = snp_op2rdy[head_q];

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      vld_d   = vld_q;
      for (int i = 0; i < DEPTH; i++) begin
         ent_d[i]        = ent_q[i];
         ent_d[i].op1    = snp_op1[i];
         ent_d[i].op1rdy = snp_op1rdy[i];
         ent_d[i].op2    = snp_op2[i];
         ent_d[i].op2rdy = snp_op2rdy[i];
      end
      if (disp) begin
         vld_d[head_q] = 1'b0;
         head_d        = head_q + PW'(1);
      end
      if (enq) begin
         ent_d[tail_q] = new_ent;
         vld_d[tail_q] = 1'b1;
         tail_d        = tail_q + PW'(1);
      end
      case ({enq, disp})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      if (rob_flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
         vld_d   = '0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         vld_q   <= '0;
         for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         vld_q   <= vld_d;
         for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
      end
   end

endmodule
